// File: rtl/panel_key_editor.sv
// panel_key_editor
//   Front-panel input block. Synchronizes and debounces the five push
//   buttons and turns each debounced press into a single-cycle event.
//   Up and down auto-repeat while they are held. The events edit a
//   4-digit BCD value under a digit cursor, and center commits that value.
//
// Ports
//   clk        in   system clock (single domain)
//   rst_n      in   synchronous active-low reset
//   btn[4:0]   in   raw buttons, active-high: up, down, left, right, center
//   key_pulse  out  one-cycle press/repeat events, same bit order as btn
//   number     out  live edit value, 4 BCD digits, [3:0] = digit 0
//   cursor     out  index of the digit under edit
//   committed  out  value latched by the last center press
//   commit     out  one-cycle strobe, coincident with the committed update

// ---------------------------------------------------------------------------
// panel_key_lane
//   One button: 2-FF synchronizer, debounce counter, rising-edge detect and,
//   when RPT_EN is set, an auto-repeat FSM.
//
// Ports
//   clk, rst_n  clock and synchronous active-low reset
//   btn_i       raw asynchronous button level
//   pulse_o     registered one-cycle event
// ---------------------------------------------------------------------------
module panel_key_lane #(
  parameter int DB_CYCLES  = 2_000_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000,
  parameter bit RPT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d, deb_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;
  logic            pulse_q, pulse_d;

  // Counter only runs while the synchronized level disagrees with the
  // debounced one, so any glitch shorter than DB_CYCLES resets it.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) deb_d = sync2_q;
      else                                  db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  generate
    if (RPT_EN) begin : g_rpt
      localparam logic [1:0] S_IDLE   = 2'd0;
      localparam logic [1:0] S_DELAY  = 2'd1;
      localparam logic [1:0] S_REPEAT = 2'd2;
      localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
      localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

      logic [1:0]       state_q, state_d;
      logic [RPT_W-1:0] rcnt_q, rcnt_d;

      // Release is checked before the count so a pulse is never emitted in
      // the cycle the debounced level is seen low.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (press) begin
              pulse_d = 1'b1;
              state_d = S_DELAY;
              rcnt_d  = '0;
            end
          end
          S_DELAY: begin
            if (!deb_q) begin
              state_d = S_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == RPT_W'(RPT_DELAY - 1)) begin
              pulse_d = 1'b1;
              state_d = S_REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d  = rcnt_q + 1'b1;
            end
          end
          S_REPEAT: begin
            if (!deb_q) begin
              state_d = S_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == RPT_W'(RPT_PERIOD - 1)) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
            end else begin
              rcnt_d  = rcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= S_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end
    end else begin : g_once
      assign pulse_d = press;
    end
  endgenerate

  assign pulse_o = pulse_q;
endmodule

// ---------------------------------------------------------------------------
// panel_key_editor (top)
// ---------------------------------------------------------------------------
module panel_key_editor #(
  parameter int DB_CYCLES  = 2_000_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn,
  output logic [4:0]  key_pulse,
  output logic [15:0] number,
  output logic [1:0]  cursor,
  output logic [15:0] committed,
  output logic        commit
);
  localparam int NUM_KEYS = 5;
  localparam int K_UP = 0, K_DN = 1, K_LT = 2, K_RT = 3, K_CT = 4;

  logic [NUM_KEYS-1:0] kp;

  // Only up/down (lanes 0 and 1) get auto-repeat.
  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      panel_key_lane #(
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD),
        .RPT_EN    (i < 2)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn[i]),
        .pulse_o(kp[i])
      );
    end
  endgenerate

  logic [15:0] number_q, number_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [15:0] committed_q, committed_d;
  logic        commit_q, commit_d;
  logic [3:0]  cur_dig;

  assign cur_dig = number_q[{cursor_q, 2'b00} +: 4];

  // One action per cycle, center > up > down > left > right; losers are
  // dropped. Digits wrap independently so number stays valid BCD.
  always_comb begin
    number_d    = number_q;
    cursor_d    = cursor_q;
    committed_d = committed_q;
    commit_d    = 1'b0;
    if (kp[K_CT]) begin
      committed_d = number_q;
      commit_d    = 1'b1;
    end else if (kp[K_UP]) begin
      number_d[{cursor_q, 2'b00} +: 4] = (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
    end else if (kp[K_DN]) begin
      number_d[{cursor_q, 2'b00} +: 4] = (cur_dig == 4'd0) ? 4'd9 : cur_dig - 4'd1;
    end else if (kp[K_LT]) begin
      cursor_d = cursor_q + 2'd1;
    end else if (kp[K_RT]) begin
      cursor_d = cursor_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      number_q    <= '0;
      cursor_q    <= '0;
      committed_q <= '0;
      commit_q    <= 1'b0;
    end else begin
      number_q    <= number_d;
      cursor_q    <= cursor_d;
      committed_q <= committed_d;
      commit_q    <= commit_d;
    end
  end

  assign key_pulse = kp;
  assign number    = number_q;
  assign cursor    = cursor_q;
  assign committed = committed_q;
  assign commit    = commit_q;
endmodule

// File: tb/tb_panel_key_editor.sv
// Bench for panel_key_editor with short debounce/repeat parameters.
// Stimulus pushes expected pulses (with their cycle) and expected state
// changes into queues; a monitor pops and compares whenever the DUT shows
// a key pulse or a number/cursor change or a commit strobe.
module tb_panel_key_editor;
  localparam int DB = 4, RD = 20, RP = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn = '0;
  logic [4:0]  key_pulse;
  logic [15:0] number, committed;
  logic [1:0]  cursor;
  logic        commit;

  panel_key_editor #(
    .DB_CYCLES (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .key_pulse(key_pulse),
    .number   (number),
    .cursor   (cursor),
    .committed(committed),
    .commit   (commit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic [4:0] kp; } pulse_t;
  typedef struct { logic [15:0] num; logic [1:0] cur; logic [15:0] comm; logic cm; } state_t;

  pulse_t pq[$];
  state_t sq[$];
  int checks = 0, errors = 0;
  logic mon_en = 1'b0;

  // reference model of the edit state
  logic [3:0]  md [4];
  logic [1:0]  mcur;
  logic [15:0] mcomm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mnum();
    return {md[3], md[2], md[1], md[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 4'd0;
    mcur  = 2'd0;
    mcomm = 16'h0000;
  endtask

  task automatic model_act(input logic [4:0] kp);
    state_t s;
    if (kp[4])      mcomm = mnum();
    else if (kp[0]) md[mcur] = (md[mcur] == 4'd9) ? 4'd0 : md[mcur] + 4'd1;
    else if (kp[1]) md[mcur] = (md[mcur] == 4'd0) ? 4'd9 : md[mcur] - 4'd1;
    else if (kp[2]) mcur = mcur + 2'd1;
    else if (kp[3]) mcur = mcur - 2'd1;
    s.num = mnum(); s.cur = mcur; s.comm = mcomm; s.cm = kp[4];
    sq.push_back(s);
  endtask

  task automatic exp_pulse(input int at, input logic [4:0] kp);
    pulse_t p;
    p.at = at; p.kp = kp;
    pq.push_back(p);
    model_act(kp);
  endtask

  // Raw level set just after an edge; the next edge is the first sampling
  // edge (cyc becomes c+1) and the pulse shows 6 edges later (cyc = c+7).
  task automatic press(input logic [4:0] bits, input int hold);
    int c;
    @(posedge clk); #1;
    btn = bits;
    c = cyc;
    exp_pulse(c + 7, bits);
    repeat (hold) @(posedge clk);
    #1 btn = '0;
    repeat (15) @(posedge clk);
  endtask

  // monitor
  initial begin
    logic [15:0] pn;
    logic [1:0]  pc;
    pulse_t p;
    state_t s;
    wait (mon_en);
    pn = number; pc = cursor;
    forever begin
      @(negedge clk);
      if (key_pulse != 5'b0) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse actual=%b expected=none (cycle %0d)", key_pulse, cyc);
        end else begin
          p = pq.pop_front();
          chk("pulse_cycle", cyc, p.at);
          chk("pulse_bits", {27'b0, key_pulse}, {27'b0, p.kp});
        end
      end
      if (number !== pn || cursor !== pc || commit) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_state actual=%h/%0d/%h/%b expected=none (cycle %0d)",
                   number, cursor, committed, commit, cyc);
        end else begin
          s = sq.pop_front();
          chk("number", {16'b0, number}, {16'b0, s.num});
          chk("cursor", {30'b0, cursor}, {30'b0, s.cur});
          chk("committed", {16'b0, committed}, {16'b0, s.comm});
          chk("commit", {31'b0, commit}, {31'b0, s.cm});
        end
      end
      pn = number; pc = cursor;
    end
  end

  // watchdog
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    state_t s;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state, then idle
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("idle_outputs", {8'b0, key_pulse, number, cursor, commit}, 32'h0);
      chk("idle_committed", {16'b0, committed}, 32'h0);
    end
    mon_en = 1'b1;

    // 3-cycle glitch is rejected
    @(posedge clk); #1 btn = 5'b00001;
    repeat (3) @(posedge clk);
    #1 btn = '0;
    repeat (15) @(posedge clk);
    #1 chk("glitch_number", {16'b0, number}, 32'h0);

    // single presses: up, down x2, left x2, up, right x3
    press(5'b00001, 10);
    press(5'b00010, 10);
    press(5'b00010, 10);
    press(5'b00100, 10);
    press(5'b00100, 10);
    press(5'b00001, 10);
    press(5'b01000, 10);
    press(5'b01000, 10);
    press(5'b01000, 10);
    // left from cursor 3 wraps to 0
    press(5'b00100, 10);

    // auto-repeat: held 58 sampling edges -> initial pulse plus +20..+55
    @(posedge clk); #1;
    btn = 5'b00001;
    c = cyc;
    exp_pulse(c + 7, 5'b00001);
    for (int k = RD; k <= 58 - 1; k += RP) exp_pulse(c + 7 + k, 5'b00001);
    repeat (58) @(posedge clk);
    #1 btn = '0;
    repeat (20) @(posedge clk);

    // simultaneous presses: center beats up, down beats left
    press(5'b10001, 10);
    press(5'b00110, 10);

    // reset while in REPEAT, button still held
    @(posedge clk); #1;
    btn = 5'b00001;
    c = cyc;
    exp_pulse(c + 7, 5'b00001);
    exp_pulse(c + 27, 5'b00001);
    while (cyc < c + 29) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    if (mnum() != 16'h0 || mcur != 2'd0) begin
      s.num = 16'h0; s.cur = 2'd0; s.comm = 16'h0; s.cm = 1'b0;
      sq.push_back(s);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_outputs", {8'b0, key_pulse, number, cursor, commit}, 32'h0);
    chk("rst_committed", {16'b0, committed}, 32'h0);
    // reset release edge is c+31; fresh press shows 6 edges later
    exp_pulse(c + 37, 5'b00001);
    while (cyc < c + 40) begin @(posedge clk); #1; end
    btn = '0;
    repeat (20) @(posedge clk);

    #1;
    chk("pulse_queue_empty", pq.size(), 0);
    chk("state_queue_empty", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
